bcd_score_scanner: RTL and testbench



---
 rtl/bcd_score_scanner.sv | 147 ++++++++++++++
 tb/tb_bcd_score_scanner.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_score_scanner.sv
// N-digit BCD score accumulator with saturating add handshake and a multiplexed
// active-low seven-segment scanner. Optional macro: LEADING_ZERO_BLANK_EN.
module bcd_score_scanner #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned POINTS_W    = 4,
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  add_valid,
    input  logic [POINTS_W-1:0]   add_pts,
    output logic                  add_ready,
    input  logic                  clear,
    output logic [4*DIGITS-1:0]   score_bcd,
    output logic                  overflow,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg
);
    localparam int unsigned SCORE_W = 4 * DIGITS;
    localparam int unsigned CNT_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W   = $clog2(DIGITS);

    typedef enum logic {IDLE, COUNT} state_t;

    state_t              state;
    logic [POINTS_W-1:0] pending;
    logic [SCORE_W-1:0]  score_inc;
    logic                all_nines;
    logic                inc_carry;
    logic [CNT_W-1:0]    refresh_cnt;
    logic [IDX_W-1:0]    digit_idx;
    logic [3:0]          cur_digit;
    logic                cur_blank;

    function automatic logic [6:0] seg_glyph(input logic [3:0] d);
        case (d)
            4'd0:    seg_glyph = 7'b1000000;
            4'd1:    seg_glyph = 7'b1111001;
            4'd2:    seg_glyph = 7'b0100100;
            4'd3:    seg_glyph = 7'b0110000;
            4'd4:    seg_glyph = 7'b0011001;
            4'd5:    seg_glyph = 7'b0010010;
            4'd6:    seg_glyph = 7'b0000010;
            4'd7:    seg_glyph = 7'b1111000;
            4'd8:    seg_glyph = 7'b0000000;
            4'd9:    seg_glyph = 7'b0010000;
            default: seg_glyph = 7'b1111111;
        endcase
    endfunction

    // Ripple BCD +1; all_nines flags the saturation point
    always_comb begin
        score_inc = score_bcd;
        all_nines = 1'b1;
        inc_carry = 1'b1;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (score_bcd[4*k +: 4] != 4'd9) all_nines = 1'b0;
            if (inc_carry) begin
                if (score_bcd[4*k +: 4] == 4'd9) begin
                    score_inc[4*k +: 4] = 4'd0;
                end else begin
                    score_inc[4*k +: 4] = score_bcd[4*k +: 4] + 4'd1;
                    inc_carry = 1'b0;
                end
            end
        end
    end

    // Accumulator FSM: one point per cycle, clear has priority over any handshake
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state     <= IDLE;
            pending   <= '0;
            score_bcd <= '0;
            overflow  <= 1'b0;
            add_ready <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (add_valid && add_ready && add_pts != '0) begin
                        pending   <= add_pts;
                        state     <= COUNT;
                        add_ready <= 1'b0;
                    end
                end
                COUNT: begin
                    if (all_nines) begin
                        overflow  <= 1'b1;
                        pending   <= '0;
                        state     <= IDLE;
                        add_ready <= 1'b1;
                    end else begin
                        score_bcd <= score_inc;
                        pending   <= pending - POINTS_W'(1);
                        if (pending == POINTS_W'(1)) begin
                            state     <= IDLE;
                            add_ready <= 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    add_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic zero_run;
`endif

    // Digit under the strobe, plus leading-zero blanking when enabled
    always_comb begin
        cur_digit = 4'd0;
        cur_blank = 1'b0;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (digit_idx == IDX_W'(k)) cur_digit = score_bcd[4*k +: 4];
        end
`ifdef LEADING_ZERO_BLANK_EN
        zero_run = 1'b1;
        for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
            zero_run = zero_run & (score_bcd[4*k +: 4] == 4'd0);
            if (zero_run && digit_idx == IDX_W'(k)) cur_blank = 1'b1;
        end
`endif
    end

    // Scanner: anode and segments registered together from the same index
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
            an          <= {{(DIGITS-1){1'b1}}, 1'b0};
            seg         <= 7'b1000000;
        end else begin
            if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
                refresh_cnt <= '0;
                digit_idx   <= (digit_idx == IDX_W'(DIGITS - 1)) ? '0 : digit_idx + IDX_W'(1);
            end else begin
                refresh_cnt <= refresh_cnt + CNT_W'(1);
            end
            an  <= ~(DIGITS'(1) << digit_idx);
            seg <= cur_blank ? 7'b1111111 : seg_glyph(cur_digit);
        end
    end
endmodule

// File: tb/tb_bcd_score_scanner.sv
// Randomized self-checking bench for bcd_score_scanner; score is modelled as a
// plain decimal integer and the display as digit extraction by division.
module tb_bcd_score_scanner;
    localparam int unsigned DIGITS      = 4;
    localparam int unsigned POINTS_W    = 4;
    localparam int unsigned REFRESH_DIV = 4;
    localparam int          MAX_SCORE   = 9999;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        add_valid = 1'b0;
    logic [3:0]  add_pts = 4'd0;
    logic        clear = 1'b0;
    logic        add_ready;
    logic [15:0] score_bcd;
    logic        overflow;
    logic [3:0]  an;
    logic [6:0]  seg;

    int checks = 0;
    int errors = 0;
    int model_score = 0;
    bit model_ov = 1'b0;

    logic [6:0] glyph [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    bcd_score_scanner #(
        .DIGITS(DIGITS), .POINTS_W(POINTS_W), .REFRESH_DIV(REFRESH_DIV)
    ) dut (
        .clk(clk), .rst(rst), .add_valid(add_valid), .add_pts(add_pts),
        .add_ready(add_ready), .clear(clear), .score_bcd(score_bcd),
        .overflow(overflow), .an(an), .seg(seg)
    );

    always #5 clk = ~clk;

    function automatic int p10(input int k);
        int r = 1;
        for (int i = 0; i < k; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) r[4*k +: 4] = 4'((v / p10(k)) % 10);
        return r;
    endfunction

    function automatic logic [6:0] model_seg(input int v, input int k);
        int d;
        d = (v / p10(k)) % 10;
`ifdef LEADING_ZERO_BLANK_EN
        if (k > 0 && v < p10(k)) return 7'b1111111;
`endif
        return glyph[d];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (score_bcd !== 16'h0000) begin errors++; $display("FAIL reset_score got %h want 0000", score_bcd); end
        checks++; if (an !== 4'b1110) begin errors++; $display("FAIL reset_an got %b want 1110", an); end
        checks++; if (seg !== 7'b1000000) begin errors++; $display("FAIL reset_seg got %b want 1000000", seg); end
        checks++; if (add_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", add_ready); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", overflow); end
        rst = 1'b0;
        model_score = 0;
        model_ov = 1'b0;
    endtask

    // One handshake, then per-cycle checks of score, overflow and add_ready
    task automatic do_add(input int p);
        int wait_cnt;
        int start;
        int n;
        int exp_score;
        bit exp_ov;
        wait_cnt = 0;
        while (add_ready !== 1'b1 && wait_cnt < 64) begin
            step();
            wait_cnt++;
        end
        checks++;
        if (add_ready !== 1'b1) begin errors++; $display("FAIL add_wait_ready got %b want 1", add_ready); end
        add_valid = 1'b1;
        add_pts = 4'(p);
        step();
        add_valid = 1'b0;
        add_pts = 4'd0;
        start = model_score;
        if (p == 0) n = 0;
        else if (start + p <= MAX_SCORE) n = p;
        else n = MAX_SCORE - start + 1;
        for (int k = 0; k <= n; k++) begin
            exp_score = (start + k > MAX_SCORE) ? MAX_SCORE : start + k;
            exp_ov = model_ov || (start + k > MAX_SCORE);
            checks++;
            if (add_ready !== (k == n)) begin errors++; $display("FAIL add_ready_cycle%0d got %b want %b", k, add_ready, (k == n)); end
            checks++;
            if (score_bcd !== to_bcd(exp_score)) begin errors++; $display("FAIL add_score_cycle%0d got %h want %h", k, score_bcd, to_bcd(exp_score)); end
            checks++;
            if (overflow !== exp_ov) begin errors++; $display("FAIL add_ovf_cycle%0d got %b want %b", k, overflow, exp_ov); end
            if (k < n) step();
        end
        if (p != 0) begin
            model_ov = model_ov || (start + p > MAX_SCORE);
            model_score = (start + p > MAX_SCORE) ? MAX_SCORE : start + p;
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        model_score = 0;
        model_ov = 1'b0;
        checks++; if (score_bcd !== 16'h0000) begin errors++; $display("FAIL clear_score got %h want 0000", score_bcd); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clear_ovf got %b want 0", overflow); end
        checks++; if (add_ready !== 1'b1) begin errors++; $display("FAIL clear_ready got %b want 1", add_ready); end
    endtask

    task automatic reach(input int target);
        if (target < model_score) pulse_clear();
        while (model_score < target) do_add((target - model_score > 15) ? 15 : target - model_score);
    endtask

    task automatic test_add();
        do_add(9);
        do_add(3);
        checks++; if (score_bcd !== 16'h0012) begin errors++; $display("FAIL add_9_3 got %h want 0012", score_bcd); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            repeat ($urandom_range(0, 2)) step();
            do_add(int'($urandom_range(0, 15)));
        end
    endtask

    task automatic test_clear();
        int s;
        s = model_score;
        add_valid = 1'b1;
        add_pts = 4'd15;
        step();
        add_valid = 1'b0;
        step();
        step();
        step();
        checks++; if (score_bcd !== to_bcd(s + 3)) begin errors++; $display("FAIL clear_pre got %h want %h", score_bcd, to_bcd(s + 3)); end
        add_valid = 1'b1;
        add_pts = 4'd5;
        pulse_clear();
        add_valid = 1'b0;
        add_pts = 4'd0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (score_bcd !== 16'h0000) begin errors++; $display("FAIL clear_hold%0d got %h want 0000", k, score_bcd); end
            checks++; if (add_ready !== 1'b1) begin errors++; $display("FAIL clear_hold_ready%0d got %b want 1", k, add_ready); end
        end
    endtask

    // Align to an anode change, then walk three full scan rotations
    task automatic test_scan(input int target);
        logic [3:0] prev;
        int wait_cnt;
        int idx0;
        int idx;
        logic [3:0] exp_an;
        reach(target);
        prev = an;
        wait_cnt = 0;
        while (an === prev && wait_cnt < 16) begin
            step();
            wait_cnt++;
        end
        checks++;
        if (an === prev || $countones(an) != 3) begin errors++; $display("FAIL scan_align got %b prev %b", an, prev); end
        idx0 = 0;
        for (int k = 0; k < 4; k++) if (an[k] === 1'b0) idx0 = k;
        for (int st = 0; st < 12; st++) begin
            idx = (idx0 + st) % 4;
            exp_an = ~(4'b0001 << idx);
            for (int c = 0; c < int'(REFRESH_DIV); c++) begin
                checks++;
                if (an !== exp_an) begin errors++; $display("FAIL scan_an score %0d got %b want %b", target, an, exp_an); end
                checks++;
                if (seg !== model_seg(target, idx)) begin errors++; $display("FAIL scan_seg score %0d digit %0d got %b want %b", target, idx, seg, model_seg(target, idx)); end
                step();
            end
        end
    endtask

    task automatic test_saturate();
        reach(9995);
        do_add(7);
        checks++; if (score_bcd !== 16'h9999) begin errors++; $display("FAIL sat_score got %h want 9999", score_bcd); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL sat_ovf got %b want 1", overflow); end
        do_add(1);
        checks++; if (score_bcd !== 16'h9999) begin errors++; $display("FAIL sat_hold got %h want 9999", score_bcd); end
        pulse_clear();
    endtask

    task automatic test_reset_mid_count();
        reach(37);
        add_valid = 1'b1;
        add_pts = 4'd15;
        step();
        add_valid = 1'b0;
        add_pts = 4'd0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_score = 0;
        model_ov = 1'b0;
        checks++; if (score_bcd !== 16'h0000) begin errors++; $display("FAIL rstmid_score got %h want 0000", score_bcd); end
        checks++; if (add_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b want 1", add_ready); end
        checks++; if (an !== 4'b1110) begin errors++; $display("FAIL rstmid_an got %b want 1110", an); end
        checks++; if (seg !== 7'b1000000) begin errors++; $display("FAIL rstmid_seg got %b want 1000000", seg); end
        do_add(3);
        checks++; if (score_bcd !== 16'h0003) begin errors++; $display("FAIL rstmid_after got %h want 0003", score_bcd); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_random();
        test_clear();
        test_scan(0);
        test_scan(5);
        test_scan(42);
        test_scan(1234);
        test_scan(9876);
        test_saturate();
        test_reset_mid_count();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
